vram_blitter: RTL
=================

// Module: vram_blitter
// PURPOSE
// - Write-side counterpart of the VGA scan-out: fills the 256x256x3-bit VRAM through its write port while the display reads the other port.
// - Accepts PLOT / FILL-RECT / CLEAR commands over a valid/ready handshake and emits one pixel write per cycle.
// - Sits between the CPU register interface and VRAM port A. Address map is the same as the display: addr = y*HSIZE + x.
// PARAMETERS
// - HSIZE    256  pixels per line; power of two; x width = log2(HSIZE)
// - VSIZE    256  lines; y width = log2(VSIZE)
// - COLOR_W  3    bits per pixel: bit0=R, bit1=B, bit2=G
// - ADDR_W   16   log2(HSIZE*VSIZE)
// PORTS
// - CLK           in   1        system clock
// - I_RESET       in   1        synchronous, active-high reset
// - I_CMD_VALID   in   1        command present
// - O_CMD_READY   out  1        blitter can accept a command
// - I_CMD_OP      in   2        00 PLOT, 01 FILL, 10 CLEAR, 11 reserved
// - I_X0, I_Y0    in   8 each   first corner (PLOT coordinate)
// - I_X1, I_Y1    in   8 each   opposite corner, FILL only
// - I_COLOR       in   COLOR_W  fill colour
// - I_HOLD        in   1        pause writes (vblank gating / arbitration)
// - O_VRAM_WE     out  1        write strobe
// - O_VRAM_ADDR   out  ADDR_W   write address {y,x}
// - O_VRAM_DATA   out  COLOR_W  write data
// - O_BUSY        out  1        command in progress (RUN or DONE state)
// - O_DONE        out  1        one-cycle pulse after the last write
// BEHAVIOUR
// - Reset: FSM=IDLE, all outputs 0 except O_CMD_READY=1 (the cycle after reset deasserts). Reset mid-command aborts immediately. No further writes occur. Pixels already written stay in VRAM.
// - FSM states: IDLE -> RUN -> DONE -> IDLE. O_CMD_READY = (state==IDLE) and not in reset.
// - Accept = I_CMD_VALID & O_CMD_READY. On accept, latch the operands:
//   - PLOT: xs=xe=X0, ys=ye=Y0.
//   - FILL: xs=min(X0,X1), xe=max(X0,X1), ys=min(Y0,Y1), ye=max(Y0,Y1). Bounds are inclusive.
//   - CLEAR: xs=ys=0, xe=HSIZE-1, ye=VSIZE-1.
//   - Reserved op: go to DONE directly with zero writes.
// - RUN: cursor starts at (xs,ys) and scans x fastest, then y.
//   - Each cycle with I_HOLD=0: WE=1, ADDR={y,x}, DATA=colour (all registered), then advance the cursor.
//   - At x==xe: x<=xs, y<=y+1. At (xe,ye): last write, next state DONE.
// - I_HOLD=1 in RUN: WE=0, cursor frozen, no write is lost or duplicated. I_HOLD is ignored in IDLE and DONE.
// - Latency: first WE in the cycle after accept (if HOLD=0). Total writes = (xe-xs+1)*(ye-ys+1).
// - DONE lasts one cycle: O_DONE=1, WE=0, READY=0. The next accept is possible in the following cycle.
// - Cursor arithmetic is 9-bit internally. Full-width CLEAR ends at x=255,y=255 with no wrap to 0 and no extra write.
// - WE=0 in IDLE and DONE. ADDR/DATA hold their last value when WE=0.
// - Operand inputs are don't-care except in the accept cycle.
// - VALID asserted while busy: ignored; the command is held off by READY=0, not dropped.
// STRUCTURE
// - Shared package vga_pkg: HSIZE, VSIZE, COLOR_W, ADDR_W, op-code localparams (OP_PLOT, OP_FILL, OP_CLEAR). The scan-out block uses the same package.
// - One sub-module: vram_rect_scanner. Holds the x/y cursor and bounds, with start/advance inputs and last/addr outputs.
// - The top level holds the FSM, operand normalisation and output registers.
// TESTING
// - PLOT (10,20) colour 5 -> exactly one write, ADDR=0x140A DATA=5 in accept+1; O_DONE at accept+2; READY at accept+3.
// - FILL (2,3)-(4,4) colour 3 -> 6 writes in order 0x0302,0x0303,0x0304,0x0402,0x0403,0x0404; no gaps; then DONE.
// - FILL (4,4)-(2,3) -> address sequence identical to the previous test (corner normalisation).
// - CLEAR colour 7 -> 65536 consecutive writes 0x0000..0xFFFF, each address once; O_DONE the cycle after 0xFFFF.
// - FILL 3x3 with I_HOLD=1 for 5 cycles after the 4th write -> WE=0 for 5 cycles; write 5 is 0x...; exactly 9 writes in total.
// - I_RESET mid-CLEAR at write 100 -> WE=0 from the next cycle, READY=1 after reset, then a PLOT executes normally. Also: reserved op -> 0 writes, O_DONE at accept+1.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA/VRAM geometry and blitter op-codes, used by both scan-out and the write-side blitter.
package vga_pkg;
  localparam int HSIZE   = 256;
  localparam int VSIZE   = 256;
  localparam int COLOR_W = 3;
  localparam int X_W     = $clog2(HSIZE);
  localparam int Y_W     = $clog2(VSIZE);
  localparam int ADDR_W  = X_W + Y_W;

  localparam logic [1:0] OP_PLOT  = 2'b00;
  localparam logic [1:0] OP_FILL  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;
endpackage

// File: rtl/vram_rect_scanner.sv
// Rectangle cursor: raster-scans (x fastest) from (xs,ys) to (xe,ye) inclusive, one step per advance.
module vram_rect_scanner
  import vga_pkg::*;
(
  input  logic              CLK,
  input  logic              I_RESET,
  input  logic              start,
  input  logic              advance,
  input  logic [X_W-1:0]    xs_in,
  input  logic [X_W-1:0]    xe_in,
  input  logic [Y_W-1:0]    ys_in,
  input  logic [Y_W-1:0]    ye_in,
  output logic              last,
  output logic [ADDR_W-1:0] addr
);
  logic [X_W:0]   x_q, cx;
  logic [Y_W:0]   y_q, cy;
  logic [X_W-1:0] xs_q, xe_q, xs, xe;
  logic [Y_W-1:0] ys_q, ye_q, ye;

  // On start the incoming bounds are used directly so the first pixel can be written in the accept edge.
  always_comb begin
    xs   = start ? xs_in : xs_q;
    xe   = start ? xe_in : xe_q;
    ye   = start ? ye_in : ye_q;
    cx   = start ? {1'b0, xs_in} : x_q;
    cy   = start ? {1'b0, ys_in} : y_q;
    last = (cx == {1'b0, xe}) && (cy == {1'b0, ye});
    addr = {cy[Y_W-1:0], cx[X_W-1:0]};
  end

  always_ff @(posedge CLK) begin
    if (I_RESET) begin
      x_q  <= '0;
      y_q  <= '0;
      xs_q <= '0;
      xe_q <= '0;
      ys_q <= '0;
      ye_q <= '0;
    end else begin
      if (start) begin
        xs_q <= xs_in;
        xe_q <= xe_in;
        ys_q <= ys_in;
        ye_q <= ye_in;
      end
      if (advance) begin
        if (cx == {1'b0, xe}) begin
          x_q <= {1'b0, xs};
          y_q <= cy + 1'b1;
        end else begin
          x_q <= cx + 1'b1;
          y_q <= cy;
        end
      end
    end
  end
endmodule

// File: rtl/vram_blitter.sv
// VRAM write-side blitter: PLOT / FILL / CLEAR commands become one registered pixel write per cycle.
module vram_blitter
  import vga_pkg::*;
(
  input  logic               CLK,
  input  logic               I_RESET,
  input  logic               I_CMD_VALID,
  output logic               O_CMD_READY,
  input  logic [1:0]         I_CMD_OP,
  input  logic [X_W-1:0]     I_X0,
  input  logic [Y_W-1:0]     I_Y0,
  input  logic [X_W-1:0]     I_X1,
  input  logic [Y_W-1:0]     I_Y1,
  input  logic [COLOR_W-1:0] I_COLOR,
  input  logic               I_HOLD,
  output logic               O_VRAM_WE,
  output logic [ADDR_W-1:0]  O_VRAM_ADDR,
  output logic [COLOR_W-1:0] O_VRAM_DATA,
  output logic               O_BUSY,
  output logic               O_DONE
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state_q;
  logic [COLOR_W-1:0] color_q;
  logic               exh_q;
  logic [X_W-1:0]     nxs, nxe;
  logic [Y_W-1:0]     nys, nye;
  logic               accept, start, emit, scan_last;
  logic [ADDR_W-1:0]  scan_addr;

  always_comb begin
    nxs = I_X0;
    nxe = I_X0;
    nys = I_Y0;
    nye = I_Y0;
    case (I_CMD_OP)
      OP_FILL: begin
        nxs = (I_X0 < I_X1) ? I_X0 : I_X1;
        nxe = (I_X0 < I_X1) ? I_X1 : I_X0;
        nys = (I_Y0 < I_Y1) ? I_Y0 : I_Y1;
        nye = (I_Y0 < I_Y1) ? I_Y1 : I_Y0;
      end
      OP_CLEAR: begin
        nxs = '0;
        nxe = X_W'(HSIZE - 1);
        nys = '0;
        nye = Y_W'(VSIZE - 1);
      end
      default: ;
    endcase
  end

  assign O_CMD_READY = (state_q == ST_IDLE) && !I_RESET;
  assign O_BUSY      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign O_DONE      = (state_q == ST_DONE);
  assign accept      = I_CMD_VALID && O_CMD_READY;
  assign start       = accept && (I_CMD_OP != OP_RSVD);
  // exh_q: the write just issued was the last one, so RUN only waits to hand over to DONE.
  assign emit        = start || ((state_q == ST_RUN) && !I_HOLD && !exh_q);

  vram_rect_scanner u_scan (
    .CLK     (CLK),
    .I_RESET (I_RESET),
    .start   (start),
    .advance (emit),
    .xs_in   (nxs),
    .xe_in   (nxe),
    .ys_in   (nys),
    .ye_in   (nye),
    .last    (scan_last),
    .addr    (scan_addr)
  );

  always_ff @(posedge CLK) begin
    if (I_RESET) begin
      state_q     <= ST_IDLE;
      color_q     <= '0;
      exh_q       <= 1'b0;
      O_VRAM_WE   <= 1'b0;
      O_VRAM_ADDR <= '0;
      O_VRAM_DATA <= '0;
    end else begin
      O_VRAM_WE <= emit;
      if (emit) begin
        O_VRAM_ADDR <= scan_addr;
        O_VRAM_DATA <= start ? I_COLOR : color_q;
        exh_q       <= scan_last;
      end
      if (start) color_q <= I_COLOR;
      case (state_q)
        ST_IDLE: if (accept) state_q <= start ? ST_RUN : ST_DONE;
        ST_RUN:  if (exh_q) state_q <= ST_DONE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule
